// File: rtl/lut_cfg_loader_if.sv
// Serial configuration stream and LUT-side outputs of the LUT configuration loader.
// The master drives the stream; the slave (the loader) drives everything else.
interface lut_cfg_loader_if #(
  parameter int CFG_WIDTH = 33
);
  logic                 cfg_start;
  logic                 cfg_bit;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 cen;
  logic [CFG_WIDTH-1:0] config_out;
  logic                 chain_bit;
  logic                 chain_valid;
  logic                 loaded;

  modport master (
    output cfg_start, cfg_bit, cfg_valid,
    input  cfg_ready, cen, config_out, chain_bit, chain_valid, loaded
  );

  modport slave (
    input  cfg_start, cfg_bit, cfg_valid,
    output cfg_ready, cen, config_out, chain_bit, chain_valid, loaded
  );
endinterface

// File: rtl/lut_cfg_loader.sv
// Bit-serial loader for the fracturable LUT: assembles {use_fracture, first_lut, second_lut},
// commits it with a one-cycle cen strobe, then forwards further bits down the daisy chain.
//
// state  | meaning
// IDLE   | after reset, waiting for cfg_start
// SHIFT  | accepting configuration bits into the shift register
// COMMIT | one cycle, cen=1, new word visible on config_out
// DONE   | word committed, extra bits forwarded to chain_bit
module lut_cfg_loader #(
  parameter  int INPUTS    = 4,
  localparam int MEM_SIZE  = 2**INPUTS,
  localparam int CFG_WIDTH = 2*MEM_SIZE + 1,
  localparam int CNT_W     = $clog2(CFG_WIDTH + 1)
) (
  input logic              cclk_i,
  input logic              rst_i,
  lut_cfg_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_WIDTH - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CFG_WIDTH-1:0] sr_q, sr_d;
  logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
  logic                 chain_bit_q, chain_bit_d;
  logic                 chain_valid_q, chain_valid_d;
  logic                 ready;
  logic                 xfer;

  always_ff @(posedge cclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sr_q          <= '0;
      cfg_q         <= '0;
      chain_bit_q   <= 1'b0;
      chain_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sr_q          <= sr_d;
      cfg_q         <= cfg_d;
      chain_bit_q   <= chain_bit_d;
      chain_valid_q <= chain_valid_d;
    end
  end

  assign ready = (state_q == SHIFT) || (state_q == DONE);
  assign xfer  = bus.cfg_valid && ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sr_d          = sr_q;
    cfg_d         = cfg_q;
    chain_bit_d   = chain_bit_q;
    chain_valid_d = 1'b0;
    if (bus.cfg_start) begin
      // a concurrent bit is dropped; config_out keeps the last committed word
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SHIFT: begin
          if (xfer) begin
            sr_d  = {sr_q[CFG_WIDTH-2:0], bus.cfg_bit};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              // output register loads on the final bit so the word is valid while cen=1
              state_d = COMMIT;
              cfg_d   = sr_d;
            end
          end
        end
        COMMIT: state_d = DONE;
        DONE: begin
          if (xfer) begin
            chain_bit_d   = bus.cfg_bit;
            chain_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.cfg_ready   = ready;
  assign bus.cen         = (state_q == COMMIT);
  assign bus.loaded      = (state_q == DONE);
  assign bus.config_out  = cfg_q;
  assign bus.chain_bit   = chain_bit_q;
  assign bus.chain_valid = chain_valid_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader: expected commit words and forwarded chain bits are queued
// as stimulus is driven and compared when cen / chain_valid appear.
module tb_lut_cfg_loader;
  localparam int W = 33;

  logic cclk = 1'b0;
  logic rst  = 1'b1;

  lut_cfg_loader_if #(.CFG_WIDTH(W)) bus ();

  lut_cfg_loader #(.INPUTS(4)) dut (
    .cclk_i (cclk),
    .rst_i  (rst),
    .bus    (bus)
  );

  always #5 cclk = ~cclk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_cfg_q[$];
  logic         exp_chain_q[$];
  logic         prev_cen = 1'b0;
  int           cen_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then inspect the registered outputs just after the edge.
  task automatic cyc(input logic s, input logic v, input logic b);
    logic [W-1:0] ew;
    logic         eb;
    bus.cfg_start = s;
    bus.cfg_valid = v;
    bus.cfg_bit   = b;
    @(posedge cclk);
    #1;
    if (bus.cen) begin
      cen_cnt++;
      chk("cen_not_back_to_back", {63'd0, prev_cen}, 64'd0);
      if (exp_cfg_q.size() == 0) chk("cen_unexpected", 64'd1, 64'd0);
      else begin
        ew = exp_cfg_q.pop_front();
        chk("commit_word", {31'd0, bus.config_out}, {31'd0, ew});
        chk("ready_in_commit", {63'd0, bus.cfg_ready}, 64'd0);
      end
    end
    prev_cen = bus.cen;
    if (bus.chain_valid) begin
      if (exp_chain_q.size() == 0) chk("chain_unexpected", 64'd1, 64'd0);
      else begin
        eb = exp_chain_q.pop_front();
        chk("chain_bit", {63'd0, bus.chain_bit}, {63'd0, eb});
      end
    end
  endtask

  // Start plus a full load of word, MSB first; gap inserts an idle cycle before each bit.
  task automatic load(input logic [W-1:0] word, input bit gap, input logic start_bit_valid);
    logic [W-1:0] w;
    w = word;
    cyc(1'b1, start_bit_valid, 1'b1);
    chk("ready_after_start", {63'd0, bus.cfg_ready}, 64'd1);
    chk("loaded_cleared", {63'd0, bus.loaded}, 64'd0);
    for (int i = W - 1; i >= 0; i--) begin
      if (gap) cyc(1'b0, 1'b0, 1'b0);
      if (i == 0) exp_cfg_q.push_back(w);
      cyc(1'b0, 1'b1, w[i]);
    end
    chk("cen_latency", {63'd0, bus.cen}, 64'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("loaded_after_commit", {63'd0, bus.loaded}, 64'd1);
    chk("ready_in_done", {63'd0, bus.cfg_ready}, 64'd1);
    chk("cen_single", {63'd0, bus.cen}, 64'd0);
  endtask

  logic [W-1:0] alt;
  logic [W-1:0] held;
  logic [2:0]   chain_pat;
  int           cen_before;

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    alt = '0;
    for (int i = 0; i < W; i++) alt[i] = (i % 2 == 0);

    #12;
    chk("rst_config_out", {31'd0, bus.config_out}, 64'd0);
    chk("rst_outputs", {58'd0, bus.cen, bus.cfg_ready, bus.chain_bit, bus.chain_valid, bus.loaded, 1'b0}, 64'd0);
    rst = 1'b0;
    @(posedge cclk); #1;
    cyc(1'b0, 1'b1, 1'b1);
    chk("idle_ignores_valid", {62'd0, bus.cfg_ready, bus.loaded}, 64'd0);

    // 1,0,1,0,... with valid held high
    load(alt, 1'b0, 1'b0);
    chk("alt_word_value", {31'd0, bus.config_out}, 64'h1_5555_5555);

    // same pattern, valid toggling
    load(alt, 1'b1, 1'b0);

    // chained bits after a completed load
    held = bus.config_out;
    cen_before = cen_cnt;
    chain_pat = 3'b110;
    for (int i = 2; i >= 0; i--) begin
      exp_chain_q.push_back(chain_pat[i]);
      cyc(1'b0, 1'b1, chain_pat[i]);
    end
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("chain_drained", exp_chain_q.size(), 0);
    chk("chain_cfg_hold", {31'd0, bus.config_out}, {31'd0, held});
    chk("chain_no_cen", cen_cnt, cen_before);
    chk("chain_valid_idle", {63'd0, bus.chain_valid}, 64'd0);

    // restart after 20 bits, then all ones
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, i[0]);
    chk("partial_cfg_hold", {31'd0, bus.config_out}, {31'd0, held});
    load({W{1'b1}}, 1'b0, 1'b0);
    chk("all_ones", {31'd0, bus.config_out}, {31'd0, {W{1'b1}}});

    // start with a concurrent valid bit: the bit must be dropped
    load(33'h0_1234_5678, 1'b0, 1'b1);
    chk("dropped_bit_word", {31'd0, bus.config_out}, 64'h0_1234_5678);

    // async reset after 32 bits
    cen_before = cen_cnt;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W - 1; i++) cyc(1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_config_out", {31'd0, bus.config_out}, 64'd0);
    chk("async_rst_outputs", {59'd0, bus.cen, bus.cfg_ready, bus.chain_bit, bus.chain_valid, bus.loaded}, 64'd0);
    bus.cfg_valid = 1'b1;
    @(posedge cclk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("no_cen_after_rst", cen_cnt, cen_before);
    chk("idle_after_rst", {62'd0, bus.cfg_ready, bus.loaded}, 64'd0);
    chk("commit_queue_empty", exp_cfg_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
